usart_tx_bamse_fifo: RTL

Transmit-side companion to the BAMSE UART receive bridge. It accepts bytes written by the BAMSE core to one bus address and buffers them in a 4-entry FIFO. It serialises them as 8N1 UART frames on `tx` and raises `int_tx` once the buffer has drained. The block sits between the BAMSE data bus (upstream) and the off-chip serial line (downstream).

---
 rtl/usart_tx_bamse_fifo.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/usart_tx_bamse_fifo.sv
// usart_tx_bamse_fifo: BAMSE bus write port feeding a 4-entry FIFO that is
// serialised as 8N1 UART frames. It raises a sticky interrupt once the
// buffer has drained and a sticky overflow flag when a write is dropped.
module usart_tx_bamse_fifo #(
  parameter logic [7:0]  ADDR  = 8'b0000_0001,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] clk_per_bit,
  input  logic [7:0]  port_in,
  input  logic [7:0]  address,
  input  logic        wen,
  output logic        tx,
  output logic        int_tx,
  output logic        full,
  output logic        tx_busy,
  output logic        ovf
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [2:0] FullCnt = 3'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [11:0] per_q, per_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        int_q, int_d;
  logic        ovf_q, ovf_d;

  logic        wr_hit;
  logic        accept;
  logic        pop;
  logic        bit_end;
  logic        set_int;
  logic [11:0] per_eff;

  // Next-state logic for the transmitter FSM, FIFO pointers and sticky flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    baud_d  = baud_q;
    per_d   = per_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    int_d   = int_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    set_int = 1'b0;

    wr_hit  = wen && (address == ADDR);
    // A rate of zero would never end a bit, so it is promoted to one cycle.
    per_eff = (clk_per_bit == 12'd0) ? 12'd1 : clk_per_bit;
    bit_end = (baud_q == per_q - 12'd1);

    case (state_q)
      StIdle: begin
        if (cnt_q != 3'd0) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          baud_d  = 12'd0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = 12'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = 12'd0;
          // Chain straight into the next start bit when more data is queued.
          if (cnt_q != 3'd0) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            set_int = 1'b1;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading a frame also latches the bit rate for its whole duration.
    if (pop) begin
      shift_d = mem_q[rptr_q];
      per_d   = per_eff;
      baud_d  = 12'd0;
      bit_d   = 3'd0;
      state_d = StStart;
      rptr_d  = rptr_q + 2'd1;
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    accept = wr_hit && ((cnt_q != FullCnt) || pop);
    if (accept) wptr_d = wptr_q + 2'd1;

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (wr_hit && !accept) ovf_d = 1'b1;

    // A write landing on the drain cycle wins over the interrupt set.
    if (accept)       int_d = 1'b0;
    else if (set_int) int_d = 1'b1;
  end

  // FIFO storage; validity is tracked by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= port_in;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      cnt_q   <= 3'd0;
      state_q <= StIdle;
      baud_q  <= 12'd0;
      per_q   <= 12'd1;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      int_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
    end
  end

  // Line level and status decoded from registered state only.
  always_comb begin
    case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
    tx_busy = (state_q != StIdle);
    full    = (cnt_q == FullCnt);
    int_tx  = int_q;
    ovf     = ovf_q;
  end

endmodule
